// File: rtl/jtcop_snd_pkg.sv
// Shared types and constants for the jtcop sound post-processing chain.
package jtcop_snd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DCB,
        ST_SAT,
        ST_OUT
    } state_t;

    localparam logic signed [23:0] S16_MAX    = 24'sd32767;
    localparam logic signed [23:0] S16_MIN    = -24'sd32768;
    localparam logic [7:0]         GAIN_UNITY = 8'h10;

    // Fractional bits of the gain word, derived from where unity sits.
    localparam int GAIN_FRAC = $clog2(GAIN_UNITY);

endpackage

// File: rtl/jtcop_snd_peak.sv
// Clip indicator stretcher: reloads on every clip, then counts down to zero.
module jtcop_snd_peak #(
    parameter logic [23:0] HOLD = 24'd480000
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic peak
);

    logic [23:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (trig)
            cnt_d = HOLD;
        else if (cnt_q != 24'd0)
            cnt_d = cnt_q - 24'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 24'd0;
        else     cnt_q <= cnt_d;
    end

    assign peak = (cnt_q != 24'd0);

endmodule

// File: rtl/jtcop_snd_post.sv
// Sound board post stage: ramped gain with soft mute, DC blocker,
// 16-bit saturation and a stretched clip indicator.
module jtcop_snd_post
    import jtcop_snd_pkg::*;
#(
    parameter int          DCB_EN    = 1,
    parameter int          DCB_K     = 10,
    parameter logic [23:0] PEAK_HOLD = 24'd480000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] snd_in,
    input  logic               sample_in,
    input  logic [7:0]         gain,
    input  logic               mute,
    output logic signed [15:0] snd,
    output logic               sample,
    output logic               peak
);

    state_t             state_q, state_d;
    logic               pend_q, pend_d;
    logic signed [15:0] pend_x_q, pend_x_d;
    logic signed [15:0] x_q, x_d;
    logic [7:0]         g_q, g_d;
    logic signed [19:0] s_q, s_d;
    logic signed [19:0] x1_q, x1_d;
    logic signed [23:0] y_q, y_d;
    logic signed [23:0] y1_q, y1_d;
    logic signed [15:0] snd_q, snd_d;
    logic               sample_q, sample_d;

    logic signed [23:0] x_ext, g_ext, p, y_calc;
    logic signed [15:0] y_sat;
    logic [7:0]         g_tgt;
    logic               clip;

    always_comb begin
        x_ext  = 24'(x_q);
        g_ext  = $signed({16'd0, g_q});
        // 16b x 9b product fits 24 bits for any 8-bit gain
        p      = x_ext * g_ext;
        g_tgt  = mute ? 8'd0 : gain;
        y_calc = 24'(s_q) - 24'(x1_q) + y1_q - (y1_q >>> DCB_K);

        if (y_q > S16_MAX)      y_sat = 16'sh7fff;
        else if (y_q < S16_MIN) y_sat = 16'sh8000;
        else                    y_sat = y_q[15:0];
        clip = (state_q == ST_SAT) && ((y_q > S16_MAX) || (y_q < S16_MIN));
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        pend_x_d = pend_x_q;
        x_d      = x_q;
        g_d      = g_q;
        s_d      = s_q;
        x1_d     = x1_q;
        y_d      = y_q;
        y1_d     = y1_q;
        snd_d    = snd_q;
        sample_d = (state_q == ST_SAT);

        // Strobes arriving while busy park in a single slot; newest wins.
        if (state_q != ST_IDLE && sample_in) begin
            pend_d   = 1'b1;
            pend_x_d = snd_in;
        end

        case (state_q)
            ST_IDLE: begin
                if (sample_in) begin
                    x_d     = snd_in;
                    pend_d  = 1'b0;
                    state_d = ST_MUL;
                end else if (pend_q) begin
                    x_d     = pend_x_q;
                    pend_d  = 1'b0;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                s_d = 20'(p >>> GAIN_FRAC);
                if (g_q < g_tgt)      g_d = g_q + 8'd1;
                else if (g_q > g_tgt) g_d = g_q - 8'd1;
                state_d = ST_DCB;
            end
            ST_DCB: begin
                if (DCB_EN != 0) begin
                    y_d  = y_calc;
                    x1_d = s_q;
                    y1_d = y_calc;
                end else begin
                    y_d  = 24'(s_q);
                end
                state_d = ST_SAT;
            end
            ST_SAT: begin
                snd_d   = y_sat;
                state_d = ST_OUT;
            end
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pend_q   <= 1'b0;
            pend_x_q <= 16'sd0;
            x_q      <= 16'sd0;
            g_q      <= 8'd0;
            s_q      <= 20'sd0;
            x1_q     <= 20'sd0;
            y_q      <= 24'sd0;
            y1_q     <= 24'sd0;
            snd_q    <= 16'sd0;
            sample_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            pend_x_q <= pend_x_d;
            x_q      <= x_d;
            g_q      <= g_d;
            s_q      <= s_d;
            x1_q     <= x1_d;
            y_q      <= y_d;
            y1_q     <= y1_d;
            snd_q    <= snd_d;
            sample_q <= sample_d;
        end
    end

    // Loaded from SAT so the indicator is already up alongside the clipped sample.
    jtcop_snd_peak #(.HOLD(PEAK_HOLD)) u_peak (
        .clk  (clk),
        .rst  (rst),
        .trig (clip),
        .peak (peak)
    );

    assign snd    = snd_q;
    assign sample = sample_q;

endmodule

// File: tb/tb_jtcop_snd_post.sv
// Directed bench: bypass instance (a) and DC-blocking instance (b) share stimulus.
module tb_jtcop_snd_post;
    import jtcop_snd_pkg::*;

    localparam logic [23:0] HOLD = 24'd20;

    logic               clk = 1'b0;
    logic               rst, sample_in, mute;
    logic signed [15:0] snd_in;
    logic [7:0]         gain;
    logic signed [15:0] snd_a, snd_b;
    logic               sample_a, sample_b, peak_a, peak_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtcop_snd_post #(.DCB_EN(0), .DCB_K(10), .PEAK_HOLD(HOLD)) dut_a (
        .clk(clk), .rst(rst), .snd_in(snd_in), .sample_in(sample_in),
        .gain(gain), .mute(mute), .snd(snd_a), .sample(sample_a), .peak(peak_a)
    );

    jtcop_snd_post #(.DCB_EN(1), .DCB_K(10), .PEAK_HOLD(HOLD)) dut_b (
        .clk(clk), .rst(rst), .snd_in(snd_in), .sample_in(sample_in),
        .gain(gain), .mute(mute), .snd(snd_b), .sample(sample_b), .peak(peak_b)
    );

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // One strobe from IDLE; returns both outputs and checks the 4-cycle latency.
    task automatic run_sample(input logic signed [15:0] v,
                              output logic signed [15:0] oa,
                              output logic signed [15:0] ob);
        bit found;
        int lat;
        found = 1'b0;
        lat   = -1;
        oa    = 16'sd0;
        ob    = 16'sd0;
        @(negedge clk);
        sample_in = 1'b1;
        snd_in    = v;
        for (int i = 1; i <= 16 && !found; i++) begin
            @(negedge clk);
            if (i == 1) sample_in = 1'b0;
            if (sample_a) begin
                found = 1'b1;
                lat   = i;
                oa    = snd_a;
                ob    = snd_b;
            end
        end
        sample_in = 1'b0;
        chk("lat", lat, 4);
    endtask

    // Strobes at cycles 0 and 2 (and 3 when three=1); reports output cycles.
    task automatic pend_run(input logic signed [15:0] v0, v1, v2, input bit three,
                            output int c1, output int c2,
                            output logic signed [15:0] o1, output logic signed [15:0] o2);
        int n;
        n  = 0;
        c1 = -1;
        c2 = -1;
        o1 = 16'sd0;
        o2 = 16'sd0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (sample_a) begin
                if (n == 0) begin c1 = c; o1 = snd_a; end
                else if (n == 1) begin c2 = c; o2 = snd_a; end
                n++;
            end
            sample_in = (c == 0) || (c == 2) || (three && c == 3);
            snd_in    = (c == 0) ? v0 : (c == 2) ? v1 : v2;
        end
        sample_in = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [15:0] oa, ob;
        int c1, c2;
        logic signed [15:0] o1, o2;
        bit any;

        rst = 1'b1; sample_in = 1'b0; snd_in = 16'sd0; gain = GAIN_UNITY; mute = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_snd", snd_a, 0);
        chk("rst_sample", sample_a, 0);
        chk("rst_peak", peak_a, 0);
        rst = 1'b0;

        // Fade-in from g_eff=0 at unity target
        for (int k = 0; k <= 16; k++) begin
            run_sample(16'sd1000, oa, ob);
            chk($sformatf("ramp%0d", k), oa, (1000 * k) / 16);
        end

        // Soft mute down to zero, then ramp back up
        mute = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            run_sample(16'sd1000, oa, ob);
            chk($sformatf("mute%0d", k), oa, (1000 * (16 - k)) / 16);
        end
        mute = 1'b0;
        for (int k = 0; k < 4; k++) begin
            run_sample(16'sd1000, oa, ob);
            chk($sformatf("unmute%0d", k), oa, (1000 * k) / 16);
        end
        repeat (14) run_sample(16'sd0, oa, ob);
        run_sample(16'sd1000, oa, ob);
        chk("unity", oa, 1000);

        // Pending path
        pend_run(16'sd100, 16'sd200, 16'sd300, 1'b0, c1, c2, o1, o2);
        chk("pend_c1", c1, 4);
        chk("pend_c2", c2, 9);
        chk("pend_o1", o1, 100);
        chk("pend_o2", o2, 200);
        pend_run(16'sd100, 16'sd200, 16'sd300, 1'b1, c1, c2, o1, o2);
        chk("newest_c2", c2, 9);
        chk("newest_o2", o2, 300);

        // Saturation and peak stretch at maximum gain
        gain = 8'hff;
        repeat (240) run_sample(16'sd0, oa, ob);
        run_sample(16'sd32767, oa, ob);
        chk("sat_pos", oa, 32767);
        chk("peak_on", peak_a, 1);
        for (int j = 1; j <= int'(HOLD); j++) begin
            @(negedge clk);
            if (j == int'(HOLD) - 1) chk("peak_hold", peak_a, 1);
            if (j == int'(HOLD))     chk("peak_fall", peak_a, 0);
        end
        run_sample(-16'sd32768, oa, ob);
        chk("sat_neg", oa, -32768);

        // Reset while the FSM sits in DCB
        run_sample(16'sd32767, oa, ob);
        @(negedge clk); sample_in = 1'b1; snd_in = 16'sd1000;
        @(negedge clk); sample_in = 1'b0;
        @(negedge clk);
        chk("pre_rst_peak", peak_a, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_snd", snd_a, 0);
        chk("mid_rst_sample", sample_a, 0);
        chk("mid_rst_peak", peak_a, 0);
        any = 1'b0;
        repeat (8) begin
            @(negedge clk);
            any = any | sample_a;
        end
        chk("no_abort_pulse", any, 0);
        gain = GAIN_UNITY;
        run_sample(16'sd1600, oa, ob);
        chk("refade0", oa, 0);
        run_sample(16'sd1600, oa, ob);
        chk("refade1", oa, 100);

        // DC blocker: constant input decays away
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (17) run_sample(16'sd0, oa, ob);
        run_sample(16'sd4000, oa, ob);
        chk("dcb_first", ob, 4000);
        chk("byp_first", oa, 4000);
        repeat (5119) run_sample(16'sd4000, oa, ob);
        // leak truncates to zero once y1 < 2^K, so the residual parks at 2^K-1
        chk("dcb_settled", ob, 1023);
        chk("byp_settled", oa, 4000);

        // DC blocker: alternating input passes nearly unchanged
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (17) run_sample(16'sd0, oa, ob);
        run_sample(16'sd4000, oa, ob);  chk("alt0", ob, 4000);
        run_sample(-16'sd4000, oa, ob); chk("alt1", ob, -4003);
        run_sample(16'sd4000, oa, ob);  chk("alt2", ob, 4001);
        run_sample(-16'sd4000, oa, ob); chk("alt3", ob, -4002);
        for (int k = 4; k < 64; k++)
            run_sample((k % 2 == 0) ? 16'sd4000 : -16'sd4000, oa, ob);
        chk("alt_amp", (ob <= -16'sd3960) && (ob >= -16'sd4040), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
